// File: rtl/flood_ctrl_multi.sv
// Multi-tank flood controller: per-tank hysteresis pumps, debounced override/speed
// buttons, a NORMAL/WARN/ALARM escalation FSM with buzzer, and a registered max-level finder.
module flood_ctrl_multi #(
  parameter int N_TANKS    = 4,
  parameter int LEVEL_W    = 5,
  parameter int HIGH_TH    = 12,
  parameter int LOW_TH     = 4,
  parameter int ALARM_TH   = 15,
  parameter int DEB_CYCLES = 4,
  parameter int ALARM_HOLD = 8,
  parameter int BEEP_DIV   = 4,
  localparam int IDX_W     = (N_TANKS > 1) ? $clog2(N_TANKS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_TANKS*LEVEL_W-1:0] level,
  input  logic                       btn0,
  input  logic                       btn7,
  output logic [N_TANKS-1:0]         pump_on,
  output logic [1:0]                 pump_speed,
  output logic                       manual,
  output logic [1:0]                 alarm_state,
  output logic                       Beep,
  output logic [LEVEL_W-1:0]         max_level,
  output logic [IDX_W-1:0]           max_idx
);
  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int HCW = $clog2(ALARM_HOLD + 1);
  localparam int BCW = $clog2(BEEP_DIV + 1);

  typedef enum logic [1:0] {
    S_NORMAL = 2'b00,
    S_WARN   = 2'b01,
    S_ALARM  = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           btn_raw;
  logic [DCW-1:0]       deb_q [2];
  logic [DCW-1:0]       deb_d [2];
  logic [1:0]           acc_q, acc_d;
  logic                 manual_q, manual_d;
  logic [1:0]           speed_q, speed_d;
  logic [N_TANKS-1:0]   auto_q, auto_d;
  logic [HCW-1:0]       hold_q, hold_d;
  logic                 beep_q, beep_d;
  logic [BCW-1:0]       div_q, div_d;
  logic [LEVEL_W-1:0]   max_q, max_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 any_high, any_alarm;

  assign btn_raw = {btn7, btn0};

  // Accept fires on the single cycle the counter steps onto DEB_CYCLES; saturation blocks repeats.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      deb_d[b] = deb_q[b];
      acc_d[b] = 1'b0;
      if (!btn_raw[b]) begin
        deb_d[b] = '0;
      end else if (deb_q[b] != DCW'(DEB_CYCLES)) begin
        deb_d[b] = deb_q[b] + 1'b1;
        acc_d[b] = (deb_q[b] == DCW'(DEB_CYCLES - 1));
      end
    end
    manual_d = manual_q ^ acc_q[0];
    speed_d  = speed_q + {1'b0, acc_q[1]};
  end

  always_comb begin
    any_high  = 1'b0;
    any_alarm = 1'b0;
    auto_d    = auto_q;
    max_d     = level[LEVEL_W-1:0];
    idx_d     = '0;
    for (int i = 0; i < N_TANKS; i++) begin
      if (level[i*LEVEL_W +: LEVEL_W] >= LEVEL_W'(HIGH_TH)) begin
        any_high  = 1'b1;
        auto_d[i] = 1'b1;
      end else if (level[i*LEVEL_W +: LEVEL_W] <= LEVEL_W'(LOW_TH)) begin
        auto_d[i] = 1'b0;
      end
      if (level[i*LEVEL_W +: LEVEL_W] >= LEVEL_W'(ALARM_TH)) any_alarm = 1'b1;
      // Strict compare keeps the lowest index on ties.
      if (level[i*LEVEL_W +: LEVEL_W] > max_d) begin
        max_d = level[i*LEVEL_W +: LEVEL_W];
        idx_d = IDX_W'(i);
      end
    end
  end

  always_comb begin
    hold_d = '0;
    if (any_alarm) hold_d = (hold_q == HCW'(ALARM_HOLD)) ? hold_q : hold_q + 1'b1;

    state_d = state_q;
    unique case (state_q)
      S_NORMAL: if (any_high) state_d = S_WARN;
      S_WARN: begin
        if (!any_high) state_d = S_NORMAL;
        else if (hold_d == HCW'(ALARM_HOLD)) state_d = S_ALARM;
      end
      S_ALARM: begin
        if (!any_high) state_d = S_NORMAL;
        else if (!any_alarm) state_d = S_WARN;
      end
      default: state_d = S_NORMAL;
    endcase

    // Buzzer starts high on the first ALARM cycle and is silenced as soon as ALARM is left.
    beep_d = 1'b0;
    div_d  = '0;
    if (state_d == S_ALARM) begin
      if (state_q != S_ALARM) begin
        beep_d = 1'b1;
      end else if (div_q == BCW'(BEEP_DIV - 1)) begin
        beep_d = ~beep_q;
      end else begin
        beep_d = beep_q;
        div_d  = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_NORMAL;
      deb_q[0] <= '0;
      deb_q[1] <= '0;
      acc_q    <= '0;
      manual_q <= 1'b0;
      speed_q  <= '0;
      auto_q   <= '0;
      hold_q   <= '0;
      beep_q   <= 1'b0;
      div_q    <= '0;
      max_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      deb_q[0] <= deb_d[0];
      deb_q[1] <= deb_d[1];
      acc_q    <= acc_d;
      manual_q <= manual_d;
      speed_q  <= speed_d;
      auto_q   <= auto_d;
      hold_q   <= hold_d;
      beep_q   <= beep_d;
      div_q    <= div_d;
      max_q    <= max_d;
      idx_q    <= idx_d;
    end
  end

  assign pump_on     = (manual_q || state_q == S_ALARM) ? '1 : auto_q;
  assign pump_speed  = (state_q == S_ALARM) ? 2'd3 : speed_q;
  assign manual      = manual_q;
  assign alarm_state = state_q;
  assign Beep        = beep_q;
  assign max_level   = max_q;
  assign max_idx     = idx_q;
endmodule

// File: tb/tb_flood_ctrl_multi.sv
// Directed bench for flood_ctrl_multi at default parameters: a vector table for
// pump hysteresis / max finder / FSM entry, plus sequences for buttons, ALARM and reset.
module tb_flood_ctrl_multi;
  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] level;
  logic        btn0, btn7;
  logic [3:0]  pump_on;
  logic [1:0]  pump_speed;
  logic        manual;
  logic [1:0]  alarm_state;
  logic        Beep;
  logic [4:0]  max_level;
  logic [1:0]  max_idx;

  int n_cmp = 0;
  int n_err = 0;

  flood_ctrl_multi dut (
    .clk(clk), .rst(rst), .level(level), .btn0(btn0), .btn7(btn7),
    .pump_on(pump_on), .pump_speed(pump_speed), .manual(manual),
    .alarm_state(alarm_state), .Beep(Beep), .max_level(max_level), .max_idx(max_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] lvl;
    logic [3:0]  pump;
    logic [4:0]  mlev;
    logic [1:0]  midx;
    logic [1:0]  alm;
  } vec_t;

  vec_t vt[11];

  function automatic logic [19:0] pack(input int t0, input int t1, input int t2, input int t3);
    return {5'(t3), 5'(t2), 5'(t1), 5'(t0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic b0, input logic b7, input int n);
    btn0 = b0;
    btn7 = b7;
    repeat (n) step();
    btn0 = 1'b0;
    btn7 = 1'b0;
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " pump_on"}, 32'(pump_on), 32'h0);
    chk({tag, " speed"}, 32'(pump_speed), 32'h0);
    chk({tag, " manual"}, 32'(manual), 32'h0);
    chk({tag, " alarm"}, 32'(alarm_state), 32'h0);
    chk({tag, " beep"}, 32'(Beep), 32'h0);
    chk({tag, " max_level"}, 32'(max_level), 32'h0);
    chk({tag, " max_idx"}, 32'(max_idx), 32'h0);
  endtask

  initial begin
    vt[0]  = '{pack(0, 0, 0, 0),   4'b0000, 5'd0,  2'd0, 2'b00};
    vt[1]  = '{pack(12, 0, 0, 0),  4'b0001, 5'd12, 2'd0, 2'b01};
    vt[2]  = '{pack(8, 0, 0, 0),   4'b0001, 5'd8,  2'd0, 2'b00};
    vt[3]  = '{pack(4, 0, 0, 0),   4'b0000, 5'd4,  2'd0, 2'b00};
    vt[4]  = '{pack(7, 9, 9, 3),   4'b0000, 5'd9,  2'd1, 2'b00};
    vt[5]  = '{pack(5, 5, 5, 5),   4'b0000, 5'd5,  2'd0, 2'b00};
    vt[6]  = '{pack(0, 0, 0, 13),  4'b1000, 5'd13, 2'd3, 2'b01};
    vt[7]  = '{pack(0, 0, 0, 5),   4'b1000, 5'd5,  2'd3, 2'b00};
    vt[8]  = '{pack(0, 0, 0, 4),   4'b0000, 5'd4,  2'd3, 2'b00};
    vt[9]  = '{pack(0, 14, 14, 0), 4'b0110, 5'd14, 2'd1, 2'b01};
    vt[10] = '{pack(0, 0, 0, 0),   4'b0000, 5'd0,  2'd0, 2'b00};

    rst = 1'b1; level = '0; btn0 = 1'b0; btn7 = 1'b0;
    repeat (2) step();
    chk_reset_outputs("reset");
    rst = 1'b0;

    for (int v = 0; v < 11; v++) begin
      level = vt[v].lvl;
      step();
      chk($sformatf("vec%0d pump_on", v), 32'(pump_on), 32'(vt[v].pump));
      chk($sformatf("vec%0d max_level", v), 32'(max_level), 32'(vt[v].mlev));
      chk($sformatf("vec%0d max_idx", v), 32'(max_idx), 32'(vt[v].midx));
      chk($sformatf("vec%0d alarm", v), 32'(alarm_state), 32'(vt[v].alm));
    end

    // Short press rejected, long press accepted exactly once.
    btn7 = 1'b1; repeat (3) step(); btn7 = 1'b0; step();
    chk("short press speed", 32'(pump_speed), 32'd0);
    btn7 = 1'b1; repeat (10) step();
    chk("long press speed", 32'(pump_speed), 32'd1);
    btn7 = 1'b0; step();
    chk("long press release speed", 32'(pump_speed), 32'd1);
    for (int p = 2; p <= 5; p++) begin
      press(1'b0, 1'b1, 5);
      chk($sformatf("press%0d speed", p), 32'(pump_speed), 32'(p % 4));
    end

    level = pack(7, 9, 9, 3);
    press(1'b1, 1'b0, 5);
    chk("manual on", 32'(manual), 32'd1);
    chk("manual pump_on", 32'(pump_on), 32'hF);
    chk("manual max_level", 32'(max_level), 32'd9);
    chk("manual max_idx", 32'(max_idx), 32'd1);

    press(1'b1, 1'b1, 5);
    chk("both manual", 32'(manual), 32'd0);
    chk("both speed", 32'(pump_speed), 32'd2);

    // Alarm escalation with a one-cycle dip restarting the hold count.
    level = '0; step();
    chk("pre-alarm normal", 32'(alarm_state), 32'd0);
    level = pack(0, 0, 15, 0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("run1 c%0d warn", k), 32'(alarm_state), 32'd1);
    end
    level = pack(0, 0, 13, 0); step();
    chk("dip warn", 32'(alarm_state), 32'd1);
    level = pack(0, 0, 15, 0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("run2 c%0d warn", k), 32'(alarm_state), 32'd1);
    end
    step();
    chk("alarm entered", 32'(alarm_state), 32'd2);
    chk("alarm pump_on", 32'(pump_on), 32'hF);
    chk("alarm speed", 32'(pump_speed), 32'd3);
    chk("alarm beep c0", 32'(Beep), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("alarm beep c%0d", k), 32'(Beep), 32'(~((k >> 2) & 1) & 1));
    end

    level = pack(0, 0, 13, 0); step();
    chk("alarm->warn state", 32'(alarm_state), 32'd1);
    chk("alarm->warn beep", 32'(Beep), 32'd0);
    chk("alarm->warn speed", 32'(pump_speed), 32'd2);
    chk("alarm->warn pump_on", 32'(pump_on), 32'h4);

    level = pack(0, 0, 15, 0);
    repeat (8) step();
    chk("re-alarm", 32'(alarm_state), 32'd2);
    level = '0; step();
    chk("drop state", 32'(alarm_state), 32'd0);
    chk("drop beep", 32'(Beep), 32'd0);
    chk("drop speed", 32'(pump_speed), 32'd2);
    chk("drop pump_on", 32'(pump_on), 32'h0);

    // Reset during ALARM with manual active and a button mid-debounce.
    press(1'b1, 1'b0, 5);
    chk("pre-rst manual", 32'(manual), 32'd1);
    level = pack(0, 0, 15, 0);
    repeat (8) step();
    chk("pre-rst alarm", 32'(alarm_state), 32'd2);
    btn7 = 1'b1; repeat (2) step();
    rst = 1'b1; step();
    chk_reset_outputs("rst in alarm");
    rst = 1'b0; btn7 = 1'b0; level = '0; step();
    chk("post-rst speed", 32'(pump_speed), 32'd0);
    chk("post-rst alarm", 32'(alarm_state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
